// File: rtl/hazard_stall_controller.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : hazard_stall_controller
// Purpose  : Decode-stage hazard scheduler. Detects load-use and Hi/Lo
//            dependence on a multi-cycle multiply/divide. Drives IF/ID freeze,
//            PC freeze and the control bubble select. Tracks the mul/div busy
//            window and keeps a saturating stall-cycle counter.
// Revision : 1.0 - initial release
// ============================================================================
module hazard_stall_controller #(
    parameter int unsigned MD_CYCLES    = 4,
    parameter logic [3:0]  HILO_READ_OP = 4'hE,
    parameter logic [3:0]  MULDIV_OP    = 4'hD
) (
    input  logic        clk,
    input  logic        rest,
    input  logic [3:0]  IFID_Op_Code,
    input  logic [3:0]  IFID_Rd,
    input  logic [3:0]  IFID_Rt,
    input  logic        IDEX_MemRead,
    input  logic [3:0]  IDEX_Rt,
    input  logic        IDEX_MD_Start,
    output logic        FrezeIFID_HD,
    output logic        Freze_PC,
    output logic        HD_Mux_Sel,
    output logic        MD_Busy,
    output logic [15:0] Stall_Count
);

    typedef enum logic [0:0] {
        ST_RUN     = 1'b0,
        ST_MD_BUSY = 1'b1
    } state_t;

    // Counter value loaded when a mul/div enters EX; the start cycle itself
    // counts as the first of the MD_CYCLES busy cycles.
    localparam logic [3:0]  C_MD_RELOAD = 4'(MD_CYCLES - 1);
    localparam logic [15:0] C_CNT_MAX   = 16'hFFFF;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [3:0]  r_md_cnt;
    logic [3:0]  w_md_cnt_nxt;
    logic [15:0] r_stall_cnt;

    logic        w_load_hz;
    logic        w_md_dep;
    logic        w_md_hz;
    logic        w_stall;

    // Hazard detection; register 0 is deliberately not excluded. Outputs are
    // gated by the reset so nothing asserts while the block is held in reset.
    assign w_load_hz = IDEX_MemRead && ((IDEX_Rt == IFID_Rd) || (IDEX_Rt == IFID_Rt));
    assign w_md_dep  = (IFID_Op_Code == HILO_READ_OP) || (IFID_Op_Code == MULDIV_OP);
    assign w_md_hz   = w_md_dep && (IDEX_MD_Start || (r_state == ST_MD_BUSY));
    assign w_stall   = rest && (w_load_hz || w_md_hz);

    assign FrezeIFID_HD = w_stall;
    assign Freze_PC     = w_stall;
    assign HD_Mux_Sel   = w_stall;
    assign MD_Busy      = rest && (r_state == ST_MD_BUSY);
    assign Stall_Count  = r_stall_cnt;

    // Next-state for the mul/div busy window; a restart beats the decrement.
    always_comb begin
        w_state_nxt  = r_state;
        w_md_cnt_nxt = r_md_cnt;
        if (IDEX_MD_Start) begin
            w_state_nxt  = ST_MD_BUSY;
            w_md_cnt_nxt = C_MD_RELOAD;
        end else if (r_state == ST_MD_BUSY) begin
            if (r_md_cnt <= 4'd1) begin
                w_state_nxt  = ST_RUN;
                w_md_cnt_nxt = 4'd0;
            end else begin
                w_md_cnt_nxt = r_md_cnt - 4'd1;
            end
        end
    end

    // State and busy-window counter registers.
    always_ff @(posedge clk or negedge rest) begin
        if (!rest) begin
            r_state  <= ST_RUN;
            r_md_cnt <= 4'd0;
        end else begin
            r_state  <= w_state_nxt;
            r_md_cnt <= w_md_cnt_nxt;
        end
    end

    // Saturating count of cycles in which the decode stage was stalled.
    always_ff @(posedge clk or negedge rest) begin
        if (!rest) begin
            r_stall_cnt <= 16'd0;
        end else if (w_stall && (r_stall_cnt != C_CNT_MAX)) begin
            r_stall_cnt <= r_stall_cnt + 16'd1;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_hazard_stall_controller.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_hazard_stall_controller
// Purpose  : Self-checking bench for hazard_stall_controller with a
//            cycle-indexed behavioural reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_hazard_stall_controller;

    localparam int MD_CYCLES = 4;

    logic        clk = 1'b0;
    logic        rest;
    logic [3:0]  op, rd, rt, idex_rt;
    logic        memread, mdstart;
    logic        frz_ifid, frz_pc, mux_sel, md_busy;
    logic [15:0] stall_cnt;

    int checks = 0;
    int errors = 0;

    // Reference model: cycle index, cycle of the most recent mul/div start,
    // and the expected stall count.
    int cyc        = 0;
    int last_start = -100;
    int m_cnt      = 0;

    always #5 clk = ~clk;

    hazard_stall_controller dut (
        .clk           (clk),
        .rest          (rest),
        .IFID_Op_Code  (op),
        .IFID_Rd       (rd),
        .IFID_Rt       (rt),
        .IDEX_MemRead  (memread),
        .IDEX_Rt       (idex_rt),
        .IDEX_MD_Start (mdstart),
        .FrezeIFID_HD  (frz_ifid),
        .Freze_PC      (frz_pc),
        .HD_Mux_Sel    (mux_sel),
        .MD_Busy       (md_busy),
        .Stall_Count   (stall_cnt)
    );

    // Busy for the MD_CYCLES-1 cycles following the start cycle.
    function automatic bit m_busy();
        return rest && (cyc > last_start) && (cyc - last_start <= MD_CYCLES - 1);
    endfunction

    function automatic bit m_stall();
        bit lhz, mhz;
        lhz = memread && ((idex_rt == rd) || (idex_rt == rt));
        mhz = ((op == 4'hE) || (op == 4'hD)) && (mdstart || m_busy());
        return rest && (lhz || mhz);
    endfunction

    task automatic set_idle();
        op = 4'h2; rd = 4'd1; rt = 4'd2; idex_rt = 4'd9;
        memread = 1'b0; mdstart = 1'b0;
    endtask

    // Advance one clock edge and update the model with the pre-edge inputs.
    task automatic tick();
        bit s, st;
        s  = m_stall();
        st = mdstart;
        @(posedge clk);
        if (!rest) begin
            m_cnt      = 0;
            last_start = -100;
        end else begin
            if (s && m_cnt < 65535) m_cnt++;
            if (st) last_start = cyc;
        end
        cyc++;
        #1;
    endtask

    task automatic test_reset();
        rest = 1'b0;
        set_idle();
        memread = 1'b1; idex_rt = 4'd2;   // would be a load-use hazard
        #12;
        checks++;
        if ({frz_ifid, frz_pc, mux_sel, md_busy} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_outputs: got %b required 0000", {frz_ifid, frz_pc, mux_sel, md_busy});
        end
        checks++;
        if (stall_cnt !== 16'd0) begin
            errors++;
            $display("FAIL reset_count: got %0d required 0", stall_cnt);
        end
        tick();
        rest = 1'b1;
        set_idle();
        tick();
    endtask

    task automatic test_load_use();
        set_idle();
        memread = 1'b1; idex_rt = 4'd5; rt = 4'd5; rd = 4'd3;
        @(negedge clk);
        checks++;
        if ({frz_ifid, frz_pc, mux_sel} !== 3'b111) begin
            errors++;
            $display("FAIL load_use_stall: got %b required 111", {frz_ifid, frz_pc, mux_sel});
        end
        tick();
        memread = 1'b0;
        @(negedge clk);
        checks++;
        if ({frz_ifid, frz_pc, mux_sel} !== 3'b000) begin
            errors++;
            $display("FAIL load_use_release: got %b required 000", {frz_ifid, frz_pc, mux_sel});
        end
        checks++;
        if (stall_cnt !== 16'd1) begin
            errors++;
            $display("FAIL load_use_count: got %0d required 1", stall_cnt);
        end
        tick();
    endtask

    task automatic test_no_hazard();
        int base;
        set_idle();
        base = m_cnt;
        memread = 1'b1; idex_rt = 4'd5; rd = 4'd3; rt = 4'd4;
        @(negedge clk);
        checks++;
        if ({frz_ifid, frz_pc, mux_sel} !== 3'b000) begin
            errors++;
            $display("FAIL no_hazard_stall: got %b required 000", {frz_ifid, frz_pc, mux_sel});
        end
        tick();
        @(negedge clk);
        checks++;
        if (stall_cnt !== 16'(base)) begin
            errors++;
            $display("FAIL no_hazard_count: got %0d required %0d", stall_cnt, base);
        end
        tick();
    endtask

    task automatic test_hilo();
        int base;
        set_idle();
        base = m_cnt;
        op = 4'hE;
        mdstart = 1'b1;
        for (int k = 0; k <= 4; k++) begin
            @(negedge clk);
            checks++;
            if ({frz_ifid, frz_pc, mux_sel} !== {3{k <= 3}}) begin
                errors++;
                $display("FAIL hilo_stall T+%0d: got %b required %b", k, {frz_ifid, frz_pc, mux_sel}, {3{k <= 3}});
            end
            checks++;
            if (md_busy !== (k >= 1 && k <= 3)) begin
                errors++;
                $display("FAIL hilo_busy T+%0d: got %b required %b", k, md_busy, (k >= 1 && k <= 3));
            end
            tick();
            mdstart = 1'b0;
        end
        checks++;
        if (stall_cnt !== 16'(base + 4)) begin
            errors++;
            $display("FAIL hilo_count: got %0d required %0d", stall_cnt, base + 4);
        end
    endtask

    task automatic test_independent();
        set_idle();
        op = 4'h2;
        mdstart = 1'b1;
        tick();
        mdstart = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            checks++;
            if ({md_busy, frz_ifid, frz_pc, mux_sel} !== 4'b1000) begin
                errors++;
                $display("FAIL independent T+%0d: busy/stall got %b required 1000", k, {md_busy, frz_ifid, frz_pc, mux_sel});
            end
            tick();
        end
    endtask

    task automatic test_both();
        int base;
        set_idle();
        base = m_cnt;
        op = 4'hE; mdstart = 1'b1; memread = 1'b1; idex_rt = 4'd5; rt = 4'd5;
        @(negedge clk);
        checks++;
        if ({frz_ifid, frz_pc, mux_sel} !== 3'b111) begin
            errors++;
            $display("FAIL both_stall: got %b required 111", {frz_ifid, frz_pc, mux_sel});
        end
        tick();
        set_idle();
        @(negedge clk);
        checks++;
        if (stall_cnt !== 16'(base + 1)) begin
            errors++;
            $display("FAIL both_count: got %0d required %0d", stall_cnt, base + 1);
        end
        for (int k = 0; k < MD_CYCLES; k++) tick();
    endtask

    task automatic test_reset_mid();
        set_idle();
        mdstart = 1'b1;
        tick();
        mdstart = 1'b0;
        tick();                            // busy window counter now at 2
        op = 4'hE; memread = 1'b1; idex_rt = 4'd5; rt = 4'd5;
        #1;
        checks++;
        if ({md_busy, frz_ifid} !== 2'b11) begin
            errors++;
            $display("FAIL reset_mid_pre: busy/stall got %b required 11", {md_busy, frz_ifid});
        end
        rest = 1'b0;
        #1;
        checks++;
        if ({md_busy, frz_ifid, frz_pc, mux_sel} !== 4'b0000 || stall_cnt !== 16'd0) begin
            errors++;
            $display("FAIL reset_mid_async: outputs %b count %0d required 0000 and 0", {md_busy, frz_ifid, frz_pc, mux_sel}, stall_cnt);
        end
        tick();
        rest = 1'b1;
        set_idle();
        op = 4'hE;
        @(negedge clk);
        checks++;
        if ({md_busy, frz_ifid} !== 2'b00 || stall_cnt !== 16'd0) begin
            errors++;
            $display("FAIL reset_mid_exit: busy/stall %b count %0d required 00 and 0", {md_busy, frz_ifid}, stall_cnt);
        end
        tick();
    endtask

    task automatic test_random();
        bit es, eb;
        for (int n = 0; n < 400; n++) begin
            memread = ($urandom_range(0, 2) == 0);
            idex_rt = 4'($urandom_range(0, 3));
            rd      = 4'($urandom_range(0, 3));
            rt      = 4'($urandom_range(0, 3));
            mdstart = ($urandom_range(0, 6) == 0);
            case ($urandom_range(0, 3))
                0:       op = 4'hE;
                1:       op = 4'hD;
                2:       op = 4'h2;
                default: op = 4'($urandom);
            endcase
            @(negedge clk);
            es = m_stall();
            eb = m_busy();
            checks++;
            if ({frz_ifid, frz_pc, mux_sel} !== {3{es}}) begin
                errors++;
                $display("FAIL random_stall cyc %0d: got %b required %b", cyc, {frz_ifid, frz_pc, mux_sel}, {3{es}});
            end
            checks++;
            if (md_busy !== eb) begin
                errors++;
                $display("FAIL random_busy cyc %0d: got %b required %b", cyc, md_busy, eb);
            end
            checks++;
            if (stall_cnt !== 16'(m_cnt)) begin
                errors++;
                $display("FAIL random_count cyc %0d: got %0d required %0d", cyc, stall_cnt, m_cnt);
            end
            tick();
        end
        set_idle();
        for (int k = 0; k < MD_CYCLES; k++) tick();
    endtask

    task automatic test_saturation();
        set_idle();
        memread = 1'b1; idex_rt = 4'd5; rt = 4'd5;
        for (int n = 0; n < 70000; n++) tick();
        @(negedge clk);
        checks++;
        if (stall_cnt !== 16'hFFFF || frz_ifid !== 1'b1) begin
            errors++;
            $display("FAIL saturation: count %h stall %b required ffff and 1", stall_cnt, frz_ifid);
        end
        tick();
        @(negedge clk);
        checks++;
        if (stall_cnt !== 16'hFFFF) begin
            errors++;
            $display("FAIL saturation_hold: count %h required ffff", stall_cnt);
        end
        set_idle();
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_no_hazard();
        test_hilo();
        test_independent();
        test_both();
        test_reset_mid();
        test_random();
        test_saturation();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
